// File: rtl/msrv32_instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_instr_fetch_if
// Description : Instruction-memory request/response bundle. The fetch
//               sequencer drives the request side (master) and the memory
//               drives the grant/response side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface msrv32_instr_fetch_if;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;

  modport master (
    output imem_req_out,
    output imem_addr_out,
    input  imem_gnt_in,
    input  imem_rvalid_in,
    input  imem_rdata_in
  );

  modport slave (
    input  imem_req_out,
    input  imem_addr_out,
    output imem_gnt_in,
    output imem_rvalid_in,
    output imem_rdata_in
  );
endinterface
`default_nettype wire

// File: rtl/msrv32_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_instr_fetch
// Description : Single-outstanding instruction-fetch sequencer. Takes the PC
//               from the PC register, issues one word fetch, captures the
//               returned instruction and holds it until decode accepts it.
//               Handles stall, flush (with late-response discard) and
//               misaligned-PC detection.
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_instr_fetch #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  wire logic               clk_in,
  input  wire logic               rst_in,
  input  wire logic [31:0]        pc_in,
  input  wire logic               fetch_en_in,
  input  wire logic               stall_in,
  input  wire logic               flush_in,
  msrv32_instr_fetch_if.master    imem,
  output logic [31:0]             instr_out,
  output logic [31:0]             instr_pc_out,
  output logic                    instr_valid_out,
  output logic                    misaligned_out,
  output logic                    busy_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  r_state;
  logic        r_req;
  logic [31:0] r_addr;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_valid;
  logic        r_misaligned;
  // Set when a flush lands after the request was granted; the response
  // still arrives and must be swallowed rather than presented to decode.
  logic        r_discard;

  assign imem.imem_req_out  = r_req;
  assign imem.imem_addr_out = r_addr;
  assign instr_out          = r_instr;
  assign instr_pc_out       = r_instr_pc;
  assign instr_valid_out    = r_valid;
  assign misaligned_out     = r_misaligned;
  assign busy_out           = (r_state != S_IDLE);

  // Fetch sequencer: request, wait for data, hold for decode.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= S_IDLE;
      r_req        <= 1'b0;
      r_addr       <= BOOT_ADDRESS;
      r_instr      <= NOP_INSTR;
      r_instr_pc   <= BOOT_ADDRESS;
      r_valid      <= 1'b0;
      r_misaligned <= 1'b0;
      r_discard    <= 1'b0;
    end else begin
      // Misaligned indication is a single-cycle pulse.
      r_misaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!flush_in && fetch_en_in) begin
            if (pc_in[1:0] != 2'b00) begin
              r_misaligned <= 1'b1;
            end else begin
              r_addr  <= pc_in;
              r_req   <= 1'b1;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (imem.imem_gnt_in) begin
            r_req     <= 1'b0;
            r_discard <= flush_in;
            r_state   <= S_WAIT;
          end else if (flush_in) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid_in) begin
            if (r_discard || flush_in) begin
              r_discard <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_instr    <= imem.imem_rdata_in;
              r_instr_pc <= r_addr;
              r_valid    <= 1'b1;
              r_state    <= S_HOLD;
            end
          end else if (flush_in) begin
            r_discard <= 1'b1;
          end
        end
        S_HOLD: begin
          if (flush_in) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_state <= S_IDLE;
          end else if (r_valid && !stall_in) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
